// File: rtl/mix_cols_engine.sv
// -----------------------------------------------------------------------------
// mix_cols_engine
//   Iterative AES MixColumns / InvMixColumns engine. A 128-bit state is
//   captured into a working register, mixed in place COLS_PER_CYCLE columns
//   per clock, then presented until the consumer takes it.
//
// Parameters
//   COLS_PER_CYCLE : columns mixed per clock (1, 2 or 4); N = 4/COLS_PER_CYCLE
//   INV_EN         : 1 keeps the inverse datapath, 0 removes it
//
// Ports
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   in_valid/ready  : input handshake; in_state (128b) and in_inv qualified
//   out_valid/ready : output handshake; out_state (128b) qualified by out_valid
//   busy            : high while columns are being mixed
//   dbg_state       : raw FSM state for checkers (IDLE=0, BUSY=1, DONE=2)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE, out_valid only in DONE; out_state
// and out_valid hold steady in DONE until the transfer. Inputs seen while not
// ready are ignored.
//
// Layout: column c is at [127-32c -: 32], row 0 in the top byte of a column.
// -----------------------------------------------------------------------------
module mix_cols_engine #(
  parameter int COLS_PER_CYCLE = 1,
  parameter int INV_EN         = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
    $error("mix_cols_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam int         N        = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] CNT_LAST = 2'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] work_q, work_d;
  logic         inv_q, inv_d;
  logic [127:0] work_mixed;

  // GF(2^8) multiply by 2 modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Mix one 32-bit column. Row i uses the same coefficient pattern rotated
  // by i, so byte k of the rotation is s[(i+k)%4].
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] s  [4];
    logic [7:0] m2 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      s[i]  = col[31-8*i -: 8];
      m2[i] = xt(s[i]);
      m4[i] = xt(m2[i]);
      m8[i] = xt(m4[i]);
    end
    for (int i = 0; i < 4; i++) begin
      if ((INV_EN != 0) && inv) begin
        // 0E*a ^ 0B*b ^ 0D*c ^ 09*d
        r[31-8*i -: 8] = (m8[i] ^ m4[i] ^ m2[i])
                       ^ (m8[(i+1)%4] ^ m2[(i+1)%4] ^ s[(i+1)%4])
                       ^ (m8[(i+2)%4] ^ m4[(i+2)%4] ^ s[(i+2)%4])
                       ^ (m8[(i+3)%4] ^ s[(i+3)%4]);
      end else begin
        // 02*a ^ 03*b ^ c ^ d
        r[31-8*i -: 8] = m2[i]
                       ^ (m2[(i+1)%4] ^ s[(i+1)%4])
                       ^ s[(i+2)%4]
                       ^ s[(i+3)%4];
      end
    end
    return r;
  endfunction

  // Columns cnt*C .. cnt*C+C-1 are replaced; the rest pass through.
  always_comb begin
    work_mixed = work_q;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      int base;
      base = 32 * (3 - (int'(cnt_q) * COLS_PER_CYCLE + j));
      work_mixed[base +: 32] = mix_col(work_q[base +: 32], inv_q);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    inv_d     = inv_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = in_state;
          inv_d   = in_inv && (INV_EN != 0);
          cnt_d   = 2'd0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        busy   = 1'b1;
        work_d = work_mixed;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = 2'd0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      work_q  <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      inv_q   <= inv_d;
    end
  end

  assign out_state = work_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mix_cols_engine.sv
// -----------------------------------------------------------------------------
// tb_mix_cols_engine
//   Four engines side by side: COLS_PER_CYCLE = 1, 2, 4 with the inverse path,
//   and COLS_PER_CYCLE = 1 with INV_EN = 0. A transaction-level model predicts
//   handshake timing and results (AES MixColumns as a matrix product over
//   GF(2^8)); one compare process checks every instance on every falling edge.
// -----------------------------------------------------------------------------
module tb_mix_cols_engine;

  localparam int NI = 4;

  localparam logic [127:0] V_IN  = 128'hDB135345_F20A225C_01010101_C6C6C6C6;
  localparam logic [127:0] V_OUT = 128'h8E4DA1BC_9FDC589D_01010101_C6C6C6C6;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid  [NI];
  logic         in_ready  [NI];
  logic [127:0] in_state  [NI];
  logic         in_inv    [NI];
  logic         out_valid [NI];
  logic         out_ready [NI];
  logic [127:0] out_state [NI];
  logic         busy      [NI];
  logic [1:0]   dbg_state [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mix_cols_engine #(
      .COLS_PER_CYCLE(g == 3 ? 1 : (1 << g)),
      .INV_EN        (g == 3 ? 0 : 1)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_state (in_state[g]),
      .in_inv   (in_inv[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_state(out_state[g]),
      .busy     (busy[g]),
      .dbg_state(dbg_state[g])
    );
  end

  function automatic int n_of(input int k);
    return (k == 3) ? 4 : (4 >> k);
  endfunction

  function automatic logic inv_en_of(input int k);
    return k != 3;
  endfunction

  // ---------------- reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Circulant matrix product: out[r] = sum_i coef[(i-r) mod 4] * s[i].
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] res;
    if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int i = 0; i < 4; i++)
          acc = acc ^ gmul(coef[(i - r + 4) % 4], s[127-32*c-8*i -: 8]);
        res[127-32*c-8*r -: 8] = acc;
      end
    end
    return res;
  endfunction

  // ---------------- transaction model ----------------
  logic [127:0] exp_q [NI][$];
  bit           m_ready [NI];
  bit           m_done  [NI];
  bit           m_zero  [NI];
  int           m_wait  [NI];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        m_ready[k] <= 1'b1;
        m_done[k]  <= 1'b0;
        m_zero[k]  <= 1'b1;
        m_wait[k]  <= 0;
        exp_q[k].delete();
      end else if (m_ready[k]) begin
        if (in_valid[k]) begin
          exp_q[k].push_back(ref_mix(in_state[k], in_inv[k] && inv_en_of(k)));
          m_ready[k] <= 1'b0;
          m_zero[k]  <= 1'b0;
          m_wait[k]  <= n_of(k);
        end
      end else if (m_wait[k] > 0) begin
        m_wait[k] <= m_wait[k] - 1;
        if (m_wait[k] == 1) m_done[k] <= 1'b1;
      end else if (m_done[k] && out_ready[k]) begin
        void'(exp_q[k].pop_front());
        m_done[k]  <= 1'b0;
        m_ready[k] <= 1'b1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int checks      = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int k, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d t=%0t: got %h expected %h", name, k, $time, act, exp);
    end
  endtask

  initial begin
    chk("pin_gmul", 0, 128'(gmul(8'h57, 8'h83)), 128'h00c1);
    chk("pin_fwd",  0, ref_mix(V_IN, 1'b0), V_OUT);
    chk("pin_inv",  0, ref_mix(V_OUT, 1'b1), V_IN);
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        chk("in_ready",  k, 128'(in_ready[k]),  128'(m_ready[k]));
        chk("out_valid", k, 128'(out_valid[k]), 128'(m_done[k]));
        chk("busy",      k, 128'(busy[k]),      128'(m_wait[k] > 0));
        if (m_zero[k]) chk("out_state_zero", k, out_state[k], 128'h0);
        if (m_done[k]) begin
          if (exp_q[k].size() == 0) chk("exp_q_empty", k, 128'h1, 128'h0);
          else                      chk("out_state", k, out_state[k], exp_q[k][0]);
        end
        if (rst_n && m_ready[k] && in_valid[k]) vectors++;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    for (int k = 0; k < NI; k++) begin
      in_valid[k]  = 1'b0;
      in_state[k]  = '0;
      in_inv[k]    = 1'b0;
      out_ready[k] = 1'b0;
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Known vector forward on C=1, its inverse on C=4, both held in DONE
    // with in_valid pulses that must be ignored.
    in_valid[0] = 1'b1; in_state[0] = V_IN;  in_inv[0] = 1'b0;
    in_valid[2] = 1'b1; in_state[2] = V_OUT; in_inv[2] = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      in_valid[0] = i[0]; in_state[0] = rnd128(); in_inv[0] = 1'(i[1]);
      in_valid[2] = i[0]; in_state[2] = rnd128(); in_inv[2] = 1'(i[1]);
      tick();
    end
    in_valid[0] = 1'b0; in_valid[2] = 1'b0;
    tick();
    out_ready[0] = 1'b1; out_ready[2] = 1'b1;
    repeat (2) tick();

    // Reset after two column updates on C=1, then a fresh transaction.
    in_valid[0] = 1'b1; in_state[0] = rnd128(); in_inv[0] = 1'b0;
    tick();
    in_valid[0] = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    in_valid[0] = 1'b1; in_state[0] = rnd128(); in_inv[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    repeat (8) tick();

    // Back-to-back on C=2: in_valid held, changing data every cycle.
    out_ready[1] = 1'b1;
    in_valid[1]  = 1'b1;
    for (int i = 0; i < 24; i++) begin
      in_state[1] = rnd128();
      in_inv[1]   = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid[1] = 1'b0;
    repeat (4) tick();

    // Random traffic on every instance.
    for (int i = 0; i < 12000; i++) begin
      for (int k = 0; k < NI; k++) begin
        in_valid[k]  = ($urandom_range(0, 3) != 0);
        in_state[k]  = rnd128();
        in_inv[k]    = 1'($urandom_range(0, 1));
        out_ready[k] = ($urandom_range(0, 3) != 0);
      end
      tick();
    end

    for (int k = 0; k < NI; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
    end
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
